mem_arbiter: RTL and testbench

- Shares the single-port program SRAM between two requesters: port 0 (host loader, read/write) and port 1 (CPU instruction fetch, read-only by convention).
- Sits between the requesters and the SRAM's CS/WE/addr/data_in/data_out pins.
- Uses registered round-robin arbitration with a bounded burst length, so the host can load or patch the program while fetch keeps getting access.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port program SRAM: host loader (port 0) and instruction fetch (port 1).
// Ownership is registered round-robin; an owner may keep the SRAM for at most MAX_BURST transfers while contended.
module mem_arbiter #(
    parameter int ADDR      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [ADDR-1:0]  addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [ADDR-1:0]  addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata1,
    output logic             mem_cs,
    output logic             mem_we,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t        owner;
    logic          last_p1;
    logic [CW-1:0] cnt;
    logic          xfer0;
    logic          xfer1;

    assign gnt0  = (owner == OWN_P0);
    assign gnt1  = (owner == OWN_P1);
    assign xfer0 = gnt0 && req0;
    assign xfer1 = gnt1 && req1;

    // The SRAM registers its own read data, so it passes straight through, qualified by rvalid.
    assign rdata0 = mem_rdata;
    assign rdata1 = mem_rdata;

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (xfer0) begin
            mem_cs    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (xfer1) begin
            mem_cs    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner   <= OWN_NONE;
            last_p1 <= 1'b1;
            cnt     <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= xfer0 && !we0;
            rvalid1 <= xfer1 && !we1;
            case (owner)
                OWN_NONE: begin
                    cnt <= '0;
                    // On a tie the port not granted most recently wins.
                    if (req0 && (!req1 || last_p1)) begin
                        owner   <= OWN_P0;
                        last_p1 <= 1'b0;
                    end else if (req1) begin
                        owner   <= OWN_P1;
                        last_p1 <= 1'b1;
                    end
                end
                OWN_P0: begin
                    if (!req0 || (req1 && cnt == CNT_LAST)) begin
                        cnt <= '0;
                        if (req1) begin
                            owner   <= OWN_P1;
                            last_p1 <= 1'b1;
                        end else begin
                            owner <= OWN_NONE;
                        end
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OWN_P1: begin
                    if (!req1 || (req0 && cnt == CNT_LAST)) begin
                        cnt <= '0;
                        if (req0) begin
                            owner   <= OWN_P0;
                            last_p1 <= 1'b0;
                        end else begin
                            owner <= OWN_NONE;
                        end
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all checked every cycle
// against a transaction-level model of ownership runs, SRAM contents and read returns.
module tb_mem_arbiter;
    localparam int ADDR      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 2 ** ADDR;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, we0, req1, we1;
    logic [ADDR-1:0]  addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic             mem_cs, mem_we;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR(ADDR), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [WIDTH-1:0] init_val(input int i);
        return (i == 3) ? 8'hA5 : WIDTH'(i * 37 + 11);
    endfunction

    // SRAM with a registered read port.
    logic [WIDTH-1:0] sram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = init_val(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_cs === 1'b1) begin
                if (mem_we === 1'b1) sram[mem_addr] <= mem_wdata;
                else                 mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Reference model: owner 0=none,1=port0,2=port1; run = cycles the owner has held the SRAM.
    int               m_owner = 0, m_last = 2, m_run = 0;
    bit               m_known = 0;
    bit               m_pv0, m_pv1;
    logic [WIDTH-1:0] m_pd0, m_pd1;
    logic [WIDTH-1:0] img [DEPTH];
    int               n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        bit x0, x1;
        x0 = (m_owner == 1) && req0;
        x1 = (m_owner == 2) && req1;
        chk("gnt0", 32'(gnt0), 32'(m_owner == 1));
        chk("gnt1", 32'(gnt1), 32'(m_owner == 2));
        chk("mem_cs", 32'(mem_cs), 32'(x0 || x1));
        chk("mem_we", 32'(mem_we), 32'(x0 ? we0 : (x1 ? we1 : 1'b0)));
        chk("mem_addr", 32'(mem_addr), x0 ? 32'(addr0) : (x1 ? 32'(addr1) : 32'd0));
        chk("mem_wdata", 32'(mem_wdata), x0 ? 32'(wdata0) : (x1 ? 32'(wdata1) : 32'd0));
        chk("rvalid0", 32'(rvalid0), 32'(m_pv0));
        chk("rvalid1", 32'(rvalid1), 32'(m_pv1));
        if (m_pv0) chk("rdata0", 32'(rdata0), 32'(m_pd0));
        if (m_pv1) chk("rdata1", 32'(rdata1), 32'(m_pd1));
    endtask

    task automatic model_step();
        bit x0, x1, mine, other;
        int nxt;
        x0 = (m_owner == 1) && req0;
        x1 = (m_owner == 2) && req1;
        m_pv0 = x0 && !we0;
        m_pv1 = x1 && !we1;
        m_pd0 = img[addr0];
        m_pd1 = img[addr1];
        if (x0 && we0) img[addr0] = wdata0;
        if (x1 && we1) img[addr1] = wdata1;
        if (reset) begin
            m_owner = 0; m_last = 2; m_run = 0;
            m_pv0 = 0; m_pv1 = 0; m_known = 1;
        end else begin
            if (m_owner == 0) begin
                if (req0 && req1) nxt = (m_last == 1) ? 2 : 1;
                else if (req0)    nxt = 1;
                else if (req1)    nxt = 2;
                else              nxt = 0;
            end else begin
                mine  = (m_owner == 1) ? req0 : req1;
                other = (m_owner == 1) ? req1 : req0;
                if (!mine)                          nxt = other ? 3 - m_owner : 0;
                else if (other && m_run >= MAX_BURST) nxt = 3 - m_owner;
                else                                nxt = m_owner;
            end
            if (nxt == 0)            m_run = 0;
            else if (nxt != m_owner) begin m_last = nxt; m_run = 1; end
            else                     m_run++;
            m_owner = nxt;
        end
    endtask

    // One clock: drive inputs just after the edge, check and advance the model at the falling edge.
    task automatic cycle(input bit rst, input bit r0, input bit w0, input int a0, input int d0,
                         input bit r1, input bit w1, input int a1, input int d1);
        @(posedge clk);
        #1;
        reset = rst; req0 = r0; we0 = w0; addr0 = ADDR'(a0); wdata0 = WIDTH'(d0);
        req1 = r1; we1 = w1; addr1 = ADDR'(a1); wdata1 = WIDTH'(d1);
        @(negedge clk);
        if (m_known) check_model();
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    bit r0s, r1s;

    initial begin
        for (int i = 0; i < DEPTH; i++) img[i] = init_val(i);
        reset = 1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

        // Reset then idle
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        chk("idle_cs", 32'(mem_cs), 0);

        // Port 1 reads SRAM[3]
        cycle(0, 0, 0, 0, 0, 1, 0, 3, 0);
        chk("t2_gnt1_c0", 32'(gnt1), 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 3, 0);
        chk("t2_gnt1_c1", 32'(gnt1), 1);
        chk("t2_addr", 32'(mem_addr), 3);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_rvalid1", 32'(rvalid1), 1);
        chk("t2_rdata1", 32'(rdata1), 32'hA5);
        idle(2);

        // Simultaneous requests right after reset, then sustained contention
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 1, 0, 2, 0);
        cycle(0, 1, 0, 1, 0, 1, 0, 2, 0);
        chk("t3_gnt0_first", 32'(gnt0), 1);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0, $urandom_range(0, DEPTH - 1), 0, 1, 0, $urandom_range(0, DEPTH - 1), 0);
            chk("t4_excl", 32'(gnt0 & gnt1), 0);
        end
        idle(3);

        // Port 0 writes addr 5, port 1 reads it back
        cycle(0, 1, 1, 5, 8'h3C, 0, 0, 0, 0);
        cycle(0, 1, 1, 5, 8'h3C, 0, 0, 0, 0);
        chk("t5_we", 32'(mem_we), 1);
        cycle(0, 0, 0, 0, 0, 1, 0, 5, 0);
        chk("t5_no_rv0", 32'(rvalid0), 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 5, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_rvalid1", 32'(rvalid1), 1);
        chk("t5_rdata1", 32'(rdata1), 32'h3C);
        idle(2);

        // Reset in the second cycle of a port-0 read burst
        cycle(0, 1, 0, 7, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 7, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 8, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 2, 0);
        chk("t6_gnt0", 32'(gnt0), 0);
        chk("t6_cs", 32'(mem_cs), 0);
        chk("t6_rvalid0", 32'(rvalid0), 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 2, 0);
        chk("t6_gnt1", 32'(gnt1), 1);

        // Random traffic with sticky requests and occasional reset
        r0s = 0; r1s = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r0s = ~r0s;
            if ($urandom_range(0, 3) == 0) r1s = ~r1s;
            cycle($urandom_range(0, 99) == 0,
                  r0s, $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
                  r1s, $urandom_range(0, 4) == 0, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
